// File: rtl/ripple_add_sequencer.sv
// Multi-cycle wide adder: one 4-bit ripple-carry slice per clock, LSB slice first.
// Optional subtract mode (a - b via ~b and carry-in 1) is enabled by defining RIPPLE_ADD_SUB_EN.
module ripple_add_sequencer #(
    parameter int WORDS = 4,
    localparam int W = 4 * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
`ifdef RIPPLE_ADD_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic [1:0]   dbg_state
);
    // Handshake: an operation is accepted on a rising edge where start=1 and ready=1;
    // start while ready=0 is dropped. done is a one-cycle pulse with sum/cout/ovf valid.

    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_next;
    logic [W-1:0]  op_a, op_b, acc, acc_next;
    logic          carry;
    logic [IW-1:0] idx;
    logic [3:0]    sa, sb, ss;
    logic [4:0]    cc;
    logic          last;
    logic [W-1:0]  b_in;
    logic          c_in;

    assign dbg_state = state;

`ifdef RIPPLE_ADD_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // The shared 4-bit full-adder chain operating on slice idx.
    always_comb begin
        sa       = op_a[{idx, 2'b00} +: 4];
        sb       = op_b[{idx, 2'b00} +: 4];
        ss       = '0;
        cc       = '0;
        cc[0]    = carry;
        for (int i = 0; i < 4; i++) begin
            ss[i]   = sa[i] ^ sb[i] ^ cc[i];
            cc[i+1] = (cc[i] & (sa[i] ^ sb[i])) | (sa[i] & sb[i]);
        end
        acc_next = acc;
        acc_next[{idx, 2'b00} +: 4] = ss;
        last     = (idx == IW'(WORDS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)     state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= a;
            op_b  <= b_in;
            carry <= c_in;
            idx   <= '0;
            acc   <= '0;
        end else if (state == RUN && !abort) begin
            acc   <= acc_next;
            carry <= cc[4];
            idx   <= idx + 1'b1;
            // Results commit only on the final slice, so an abort leaves them untouched.
            if (last) begin
                sum  <= acc_next;
                cout <= cc[4];
                ovf  <= cc[3] ^ cc[4];
            end
        end
    end

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Scoreboard bench for ripple_add_sequencer (WORDS=4); directed vectors with hand-computed results.
module tb_ripple_add_sequencer;
    localparam int WORDS = 4;
    localparam int W = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ready, busy, done, cout, ovf;
    logic [W-1:0] sum;
    logic [1:0]   dbg_state;

    logic [W+1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    ripple_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef RIPPLE_ADD_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin), .ready(ready), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf), .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: compare every done pulse against the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=sum %h required=no done", sum);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("result_sum", 32'(sum), 32'(e[W+1:2]));
                check("result_cout", 32'(cout), 32'(e[1]));
                check("result_ovf", 32'(ovf), 32'(e[0]));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // driver: issue one op at a negedge, push expectation, check timing
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic vs, input logic [W-1:0] es, input logic ec, input logic eo);
        wait_ready();
        start = 1'b1; a = va; b = vb; cin = vc; sub = vs;
        exp_q.push_back({es, ec, eo});
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        for (int i = 0; i < WORDS; i++) begin
            check("busy_run", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("ready_in_done", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready_after", 32'(ready), 32'd1);
        check("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start with abort in IDLE: start wins
        wait_ready();
        abort = 1'b1;
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // start pulsed during RUN is ignored
        wait_ready();
        start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        exp_q.push_back({16'h0100, 1'b0, 1'b0});
        @(negedge clk);
        a = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        repeat (WORDS + 2) @(negedge clk);
        check("ignored_start_idle", 32'(ready), 32'd1);

        // start held high: second op accepted only once ready returns
        start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        exp_q.push_back({16'h0003, 1'b0, 1'b0});
        @(negedge clk);
        a = 16'h1000; b = 16'h0100; cin = 1'b1;
        exp_q.push_back({16'h1101, 1'b0, 1'b0});
        repeat (WORDS) @(negedge clk);
        check("held_done", 32'(done), 32'd1);
        @(negedge clk);
        check("held_ready", 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("held_second_busy", 32'(busy), 32'd1);
        repeat (WORDS + 2) @(negedge clk);

        // abort at second RUN edge keeps the previous result
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (WORDS + 2) @(negedge clk);
        check("abort_sum", 32'(sum), 32'h2345);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);

        // commit a nonzero cout/ovf, then reset mid-RUN
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WORDS + 3) @(negedge clk);

`ifdef RIPPLE_ADD_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
